serial_subtractor: RTL and testbench

//  Bit-serial unsigned subtractor: diff = A - B - bin, processed LSB-first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 10 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 89 ++++++++
 tb/tb_serial_subtractor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - br, bo is the borrow into the next bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic br,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ br;
  assign bo = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock behind a start/busy/done handshake.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             d_bit;
  logic             bo_bit;

  full_subtractor u_fs (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .br (borrow),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // Result fills from the MSB so after WIDTH shifts bit 0 holds the first computed bit.
  always_comb begin
    res_next           = res_sh >> 1;
    res_next[WIDTH-1]  = d_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            borrow <= bin;
            res_sh <= '0;
            cnt    <= '0;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          borrow <= bo_bit;
          res_sh <= res_next;
          cnt    <= cnt + CNT_W'(1);
          // Outputs change only here, so no partial result is ever visible.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            diff  <= res_next;
            bout  <= bo_bit;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_SHIFT) || (state == S_DONE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=2: directed vectors plus an exhaustive sweep.
module tb_serial_subtractor;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         bin;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W:0]   exp;
  } txn_t;

  txn_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse pops one expected transaction.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with diff=%0d bout=%0d, expected no result", diff, bout);
      end else begin
        txn_t t;
        t = sb.pop_front();
        check("result", int'({bout, diff}), int'(t.exp));
        check("identity", int'(diff) + int'(t.b) + int'(t.bi), int'(t.a) + 4 * int'(bout));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input logic [W:0] exp);
    txn_t t;
    wait_idle();
    A = a; B = b; bin = bi; start = 1'b1;
    t.a = a; t.b = b; t.bi = bi; t.exp = exp;
    sb.push_back(t);
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b; bin = ~bi;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("done_timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    int bc, done_at, d0, seen, last, n;
    logic [W:0] e;
    reset = 1'b1; start = 1'b0; A = '0; B = '0; bin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_diff", int'(diff), 0);
    check("reset_bout", int'(bout), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clk);

    // Scenario 1: latency and busy window
    issue(2'd0, 2'd0, 1'b0, 3'd0);
    bc = 0; done_at = -1;
    for (int i = 0; i < 6; i++) begin
      if (busy) bc++;
      if (done) done_at = i;
      @(negedge clk);
    end
    check("busy_cycles", bc, W + 1);
    check("done_latency", done_at, W);

    // Scenario 2: directed vectors, plus result hold during the next operation
    issue(2'd1, 2'd2, 1'b0, 3'b111);
    wait_done();
    issue(2'd3, 2'd1, 1'b1, 3'b001);
    check("hold_diff", int'(diff), 3);
    check("hold_bout", int'(bout), 1);
    wait_done();
    issue(2'd0, 2'd3, 1'b1, 3'b100);
    wait_done();

    // Scenario 3: exhaustive sweep
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int bi = 0; bi < 2; bi++) begin
          e = {1'b0, 2'(a)} - {1'b0, 2'(b)} - {2'b00, 1'(bi)};
          issue(2'(a), 2'(b), 1'(bi), e);
        end
    wait_done();

    // Scenario 4: start while busy is ignored
    wait_idle();
    d0 = done_cnt;
    A = 2'd3; B = 2'd0; bin = 1'b0; start = 1'b1;
    begin
      txn_t t;
      t.a = 2'd3; t.b = 2'd0; t.bi = 1'b0; t.exp = 3'd3;
      sb.push_back(t);
    end
    @(negedge clk);
    A = 2'd2; B = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);
    check("single_done", done_cnt - d0, 1);

    // Scenario 5: reset mid-SHIFT discards the operation
    issue(2'd1, 2'd1, 1'b0, 3'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    check("midrst_diff", int'(diff), 0);
    check("midrst_bout", int'(bout), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    issue(2'd2, 2'd1, 1'b0, 3'd1);
    wait_done();

    // Scenario 6: start held high, one operation every W+2 cycles
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      txn_t t;
      t.a = 2'd2; t.b = 2'd2; t.bi = 1'b1; t.exp = 3'b111;
      sb.push_back(t);
    end
    A = 2'd2; B = 2'd2; bin = 1'b1; start = 1'b1;
    seen = 0; last = 0; n = 0;
    while (seen < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen++;
        if (seen > 1) check("period", cyc - last, W + 2);
        last = cyc;
      end
    end
    start = 1'b0;
    check("held_ops", seen, 3);
    repeat (6) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
